// File: rtl/network_pkg.sv
// Classifier rule record types shared by the rule table writer and the matchers.
package network_pkg;

   localparam int PROTOCOL_SIZE = 8;
   localparam int IP_SIZE       = 32;
   localparam int PORT_SIZE     = 16;

   typedef struct packed {
      logic [IP_SIZE-1:0]   ip;
      logic [PORT_SIZE-1:0] port;
   } endpoint_s;

   typedef struct packed {
      logic [PROTOCOL_SIZE-1:0] protocol;
      endpoint_s                src;
      endpoint_s                dst;
   } key_s;

   typedef struct packed {
      key_s start;
      key_s last;
   } rule_s;

endpackage

// File: rtl/rule_table_loader_if.sv
// Rule word stream from the host configuration bus into the rule table loader.
interface rule_table_loader_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;

   modport master (output s_data, output s_valid, output s_last, input s_ready);
   modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/rule_table_loader.sv
// Reassembles 10-word rule streams into rule_s records, validates them against
// half-open [start, last) semantics and writes accepted rules to the next free slot.
module rule_table_loader
   import network_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   rule_table_loader_if.slave  s,
   output logic                wr_en,
   output logic [ADDR_W-1:0]   wr_addr,
   output rule_s               wr_rule,
   output logic [ADDR_W:0]     rule_count,
   output logic                full,
   output logic                err_valid,
   output logic [1:0]          err_code
);

   typedef enum logic [1:0] {ST_COLLECT, ST_DROP, ST_CHECK, ST_RESULT} state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      LAST_IDX = 4'd9;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_idx;
   logic                r_len_err;
   logic                r_ovf_err;
   logic [ADDR_W:0]     r_count;
   logic                r_wr_en;
   logic [ADDR_W-1:0]   r_wr_addr;
   rule_s               r_wr_rule;
   logic                r_err_valid;
   logic [1:0]          r_err_code;
   rule_s               r_asm;
   logic                w_full;
   logic                w_ready;
   logic                w_accept;
   logic                w_ovf;
   logic [1:0]          w_code;

   function automatic logic [31:0] width_mask(input int w);
      logic [32:0] t;
      t = (33'd1 << w) - 33'd1;
      return t[31:0];
   endfunction

   function automatic logic [31:0] field_mask(input logic [3:0] idx);
      case (idx)
         4'd0, 4'd5:               return width_mask(PROTOCOL_SIZE);
         4'd1, 4'd3, 4'd6, 4'd8:   return width_mask(IP_SIZE);
         default:                  return width_mask(PORT_SIZE);
      endcase
   endfunction

   // Any field where last does not exceed start leaves an empty half-open range.
   function automatic logic empty_range(input rule_s r);
      return (r.last.protocol <= r.start.protocol) ||
             (r.last.src.ip   <= r.start.src.ip)   ||
             (r.last.src.port <= r.start.src.port) ||
             (r.last.dst.ip   <= r.start.dst.ip)   ||
             (r.last.dst.port <= r.start.dst.port);
   endfunction

   assign w_full     = (r_count == FULL_CNT);
   assign w_ovf      = |(s.s_data & ~field_mask(r_idx));
   assign w_code     = r_len_err ? 2'd1 : (r_ovf_err ? 2'd2 : (empty_range(r_asm) ? 2'd3 : 2'd0));
   assign s.s_ready  = w_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_COLLECT;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      case (r_state)
         ST_COLLECT: w_ready = !w_full;
         ST_DROP:    w_ready = 1'b1;
         default:    w_ready = 1'b0;
      endcase
      w_accept = s.s_valid && w_ready;
      case (r_state)
         ST_COLLECT: begin
            if (w_accept && s.s_last)               w_state_nxt = ST_CHECK;
            else if (w_accept && r_idx == LAST_IDX) w_state_nxt = ST_DROP;
         end
         ST_DROP:   if (w_accept && s.s_last) w_state_nxt = ST_CHECK;
         ST_CHECK:  w_state_nxt = ST_RESULT;
         ST_RESULT: w_state_nxt = ST_COLLECT;
         default:   w_state_nxt = ST_COLLECT;
      endcase
      if (clear) w_state_nxt = ST_COLLECT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= '0;
         r_len_err   <= 1'b0;
         r_ovf_err   <= 1'b0;
         r_count     <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_rule   <= '0;
         r_err_valid <= 1'b0;
         r_err_code  <= '0;
      end else if (clear) begin
         r_idx       <= '0;
         r_len_err   <= 1'b0;
         r_ovf_err   <= 1'b0;
         r_count     <= '0;
         r_wr_en     <= 1'b0;
         r_err_valid <= 1'b0;
      end else begin
         r_wr_en     <= 1'b0;
         r_err_valid <= 1'b0;
         case (r_state)
            ST_COLLECT: begin
               if (w_accept) begin
                  r_ovf_err <= r_ovf_err | w_ovf;
                  if (s.s_last ? (r_idx != LAST_IDX) : (r_idx == LAST_IDX)) r_len_err <= 1'b1;
                  if (!s.s_last && r_idx != LAST_IDX) r_idx <= r_idx + 4'd1;
               end
            end
            ST_CHECK: begin
               if (w_code == 2'd0) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_count[ADDR_W-1:0];
                  r_wr_rule <= r_asm;
               end else begin
                  r_err_valid <= 1'b1;
                  r_err_code  <= w_code;
               end
            end
            ST_RESULT: begin
               if (r_wr_en) r_count <= r_count + (ADDR_W+1)'(1);
               r_idx     <= '0;
               r_len_err <= 1'b0;
               r_ovf_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Assembly register holds data only; its contents are qualified by the flags above.
   always_ff @(posedge clk) begin
      if (r_state == ST_COLLECT && w_accept && !clear) begin
         case (r_idx)
            4'd0:    r_asm.start.protocol <= s.s_data[PROTOCOL_SIZE-1:0];
            4'd1:    r_asm.start.src.ip   <= s.s_data[IP_SIZE-1:0];
            4'd2:    r_asm.start.src.port <= s.s_data[PORT_SIZE-1:0];
            4'd3:    r_asm.start.dst.ip   <= s.s_data[IP_SIZE-1:0];
            4'd4:    r_asm.start.dst.port <= s.s_data[PORT_SIZE-1:0];
            4'd5:    r_asm.last.protocol  <= s.s_data[PROTOCOL_SIZE-1:0];
            4'd6:    r_asm.last.src.ip    <= s.s_data[IP_SIZE-1:0];
            4'd7:    r_asm.last.src.port  <= s.s_data[PORT_SIZE-1:0];
            4'd8:    r_asm.last.dst.ip    <= s.s_data[IP_SIZE-1:0];
            4'd9:    r_asm.last.dst.port  <= s.s_data[PORT_SIZE-1:0];
            default: ;
         endcase
      end
   end

   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_rule    = r_wr_rule;
   assign rule_count = r_count;
   assign full       = w_full;
   assign err_valid  = r_err_valid;
   assign err_code   = r_err_code;

endmodule

// File: tb/tb_rule_table_loader.sv
// Directed bench for rule_table_loader: table of rule streams plus fill/clear/reset sequences.
module tb_rule_table_loader;
   import network_pkg::*;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = $clog2(DEPTH);

   typedef struct {
      logic [10:0][31:0] w;
      int                n;
      bit                ok;
      logic [1:0]        code;
      rule_s             exp;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clear = 1'b0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   rule_s             wr_rule;
   logic [ADDR_W:0]   rule_count;
   logic              full;
   logic              err_valid;
   logic [1:0]        err_code;

   int n_chk = 0;
   int n_pass = 0;
   int n_wr = 0;
   int n_err = 0;
   int exp_count = 0;

   rule_table_loader_if bus();

   rule_table_loader #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .s(bus),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_rule(wr_rule),
      .rule_count(rule_count), .full(full),
      .err_valid(err_valid), .err_code(err_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wr_en)     n_wr++;
      if (err_valid) n_err++;
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      else n_pass++;
   endtask

   function automatic key_s mk_key(input logic [31:0] p, input logic [31:0] sip,
                                   input logic [31:0] sp, input logic [31:0] dip,
                                   input logic [31:0] dp);
      key_s k;
      k.protocol = p[PROTOCOL_SIZE-1:0];
      k.src.ip   = sip[IP_SIZE-1:0];
      k.src.port = sp[PORT_SIZE-1:0];
      k.dst.ip   = dip[IP_SIZE-1:0];
      k.dst.port = dp[PORT_SIZE-1:0];
      return k;
   endfunction

   // Drive n words, one acceptance per loop pass; returns at #1 after the final accepting edge.
   task automatic send_words(input logic [10:0][31:0] w, input int n, input bit with_last);
      int k;
      for (int i = 0; i < n; i++) begin
         bus.s_data  = w[i];
         bus.s_valid = 1'b1;
         bus.s_last  = with_last && (i == n - 1);
         k = 0;
         while (!bus.s_ready && k < 40) begin
            @(posedge clk); #1;
            k++;
         end
         if (!bus.s_ready) begin
            chk("ready_timeout", 256'(bus.s_ready), 256'(1));
            bus.s_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      send_words(v.w, v.n, 1'b1);
      chk({nm, "_check_ready"}, 256'(bus.s_ready), 256'(0));
      @(posedge clk); #1;
      if (v.ok) begin
         chk({nm, "_wr_en"},   256'(wr_en),     256'(1));
         chk({nm, "_wr_addr"}, 256'(wr_addr),   256'(exp_count));
         chk({nm, "_wr_rule"}, 256'(wr_rule),   256'(v.exp));
         chk({nm, "_err_vld"}, 256'(err_valid), 256'(0));
         exp_count++;
      end else begin
         chk({nm, "_err_vld"}, 256'(err_valid), 256'(1));
         chk({nm, "_err_code"},256'(err_code),  256'(v.code));
         chk({nm, "_wr_en"},   256'(wr_en),     256'(0));
      end
      @(posedge clk); #1;
      chk({nm, "_pulse_end"}, 256'({wr_en, err_valid}), 256'(0));
      chk({nm, "_count"},     256'(rule_count),         256'(exp_count));
      chk({nm, "_ready"},     256'(bus.s_ready),        256'(exp_count != DEPTH));
   endtask

   vec_t tv[10];
   logic [10:0][31:0] base;
   rule_s base_rule;

   initial begin
      int wr0, er0, hi;
      bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;

      base[0] = 32'd6;  base[1] = 32'h0A00_0000; base[2] = 32'd0;     base[3] = 32'd0;
      base[4] = 32'd80; base[5] = 32'd7;         base[6] = 32'h0A00_0100; base[7] = 32'd65535;
      base[8] = 32'hFFFF_FFFF; base[9] = 32'd81; base[10] = 32'h1234;
      base_rule.start = mk_key(6, 32'h0A00_0000, 0, 0, 80);
      base_rule.last  = mk_key(7, 32'h0A00_0100, 65535, 32'hFFFF_FFFF, 81);

      for (int i = 0; i < 10; i++) begin
         tv[i].w = base; tv[i].n = 10; tv[i].ok = 1'b0; tv[i].code = 2'd0; tv[i].exp = base_rule;
      end
      tv[0].ok = 1'b1;                                       // valid rule -> addr 0
      tv[1].n = 4;  tv[1].code = 2'd1;                       // early s_last
      tv[2].w[9] = 32'd82; tv[2].ok = 1'b1;                  // valid -> addr 1
      tv[2].exp.last.dst.port = 16'd82;
      tv[3].n = 11; tv[3].code = 2'd1;                       // eleven words
      tv[4].w[0] = 32'h100; tv[4].code = 2'd2;               // protocol overflow
      tv[5].w[2] = 32'd80; tv[5].w[7] = 32'd80; tv[5].code = 2'd3; // empty port range
      tv[6].w[0] = 32'h100; tv[6].n = 5; tv[6].code = 2'd1;  // length beats overflow
      tv[7].w[0] = 32'h107; tv[7].code = 2'd2;               // overflow beats range
      tv[8].w[0] = 32'hFE; tv[8].w[5] = 32'hFF; tv[8].w[3] = 32'hFFFF_FFFE;
      tv[8].w[4] = 32'hFFFE; tv[8].w[9] = 32'hFFFF; tv[8].ok = 1'b1; // max field values
      tv[8].exp.start = mk_key(32'hFE, 32'h0A00_0000, 0, 32'hFFFF_FFFE, 32'hFFFE);
      tv[8].exp.last  = mk_key(32'hFF, 32'h0A00_0100, 65535, 32'hFFFF_FFFF, 32'hFFFF);
      tv[9].ok = 1'b1;                                       // fills the table

      #12;
      chk("rst_ready",     256'(bus.s_ready), 256'(1));
      chk("rst_wr_en",     256'(wr_en),       256'(0));
      chk("rst_wr_addr",   256'(wr_addr),     256'(0));
      chk("rst_wr_rule",   256'(wr_rule),     256'(0));
      chk("rst_count",     256'(rule_count),  256'(0));
      chk("rst_full",      256'(full),        256'(0));
      chk("rst_err",       256'({err_valid, err_code}), 256'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) run_vec(tv[i], $sformatf("vec%0d", i));
      chk("full_flag", 256'(full), 256'(1));

      // Full table: s_ready must hold low while a word waits.
      wr0 = n_wr; er0 = n_err; hi = 0;
      bus.s_data = base[0]; bus.s_valid = 1'b1; bus.s_last = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.s_ready) hi++;
      end
      chk("full_hold_ready", 256'(hi), 256'(0));
      chk("full_hold_count", 256'(rule_count), 256'(DEPTH));
      chk("full_no_events", 256'((n_wr - wr0) + (n_err - er0)), 256'(0));

      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; bus.s_valid = 1'b0;
      exp_count = 0;
      chk("clr_count", 256'(rule_count), 256'(0));
      chk("clr_full",  256'(full),       256'(0));
      chk("clr_ready", 256'(bus.s_ready), 256'(1));
      run_vec(tv[0], "after_clear");

      // Clear landing in the RESULT cycle: write still visible, count ends at 0.
      send_words(base, 10, 1'b1);
      @(posedge clk); #1;
      chk("clrres_wr_en", 256'(wr_en),   256'(1));
      chk("clrres_addr",  256'(wr_addr), 256'(1));
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      exp_count = 0;
      chk("clrres_count", 256'(rule_count), 256'(0));
      chk("clrres_ready", 256'(bus.s_ready), 256'(1));

      // Reset after five words of a rule discards it.
      run_vec(tv[0], "pre_reset");
      send_words(base, 5, 1'b0);
      wr0 = n_wr; er0 = n_err;
      rst_n = 1'b0;
      #3;
      chk("mid_rst_count", 256'(rule_count), 256'(0));
      @(negedge clk); rst_n = 1'b1;
      exp_count = 0;
      repeat (15) @(posedge clk);
      #1;
      chk("mid_rst_no_events", 256'((n_wr - wr0) + (n_err - er0)), 256'(0));
      chk("mid_rst_count2", 256'(rule_count), 256'(0));
      run_vec(tv[2], "post_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
